instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port `rst`: input, 1 bit, asynchronous, active-high reset.
REQ-003 The block SHALL have port `fetch_req`: input, 1 bit, one-cycle request from the control unit for the next instruction.
REQ-004 The block SHALL have port `pc_load`: input, 1 bit, which loads the PC for a jump or branch.
REQ-005 The block SHALL have port `pc_load_val`: input, 16 bits, the new PC value.
REQ-006 The block SHALL have port `ram_rdata`: input, 16 bits, synchronous RAM read data, valid one cycle after `ram_rd`.
REQ-007 The block SHALL have port `ram_addr`: output, 16 bits, RAM read address.
REQ-008 The block SHALL have port `ram_rd`: output, 1 bit, RAM read strobe.
REQ-009 The block SHALL have port `instr`: output, 16 bits, registered instruction word, the `instr` operand of the control unit.
REQ-010 The block SHALL have port `instr_valid`: output, 1 bit, a one-cycle pulse when `instr` is updated.
REQ-011 The block SHALL have port `pc`: output, 16 bits, the current program counter.
REQ-012 The block SHALL have port `busy`: output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, READ, CAPTURE.
- IDLE -> READ on `fetch_req`.
- READ -> CAPTURE unconditionally.
- CAPTURE -> IDLE unconditionally.
REQ-014 In READ, the block SHALL drive `ram_rd`=1 and `ram_addr`=`pc`.
- In all other states, `ram_rd`=0 and `ram_addr` holds its last value.
REQ-015 In CAPTURE, at the closing edge, the block SHALL:
- set `instr` <= `ram_rdata`;
- set `pc` <= `pc`+1;
- assert `instr_valid` for exactly the following cycle.
REQ-016 Latency SHALL be fixed: `fetch_req` sampled at edge N gives `instr_valid`=1 in the cycle after edge N+2.
REQ-017 PC increment SHALL be 16-bit modulo: 0xFFFF wraps to 0x0000.
REQ-018 A `fetch_req` arriving while `busy`=1 SHALL be ignored and not queued.
REQ-019 A `pc_load` in IDLE SHALL set `pc` <= `pc_load_val` at the next edge.
REQ-020 A `pc_load` together with `fetch_req` in IDLE SHALL load `pc_load_val` and enter READ.
- The READ cycle then addresses the new PC.
REQ-021 A `pc_load` in READ or CAPTURE SHALL abort the fetch:
- `pc` <= `pc_load_val`;
- return to IDLE;
- discard the RAM data;
- leave `instr` unchanged;
- produce no `instr_valid` pulse.
REQ-022 `instr` SHALL hold its value between fetches.

Reset
REQ-023 While `rst`=1, the block SHALL immediately force the following, independent of `clk`:
- state=IDLE;
- `pc`=0x0000;
- `instr`=0x0000;
- `instr_valid`=0;
- `ram_rd`=0;
- `ram_addr`=0x0000;
- `busy`=0.
REQ-024 Reset asserted mid-fetch SHALL abandon the fetch with no `instr_valid` pulse after release.
REQ-025 The first `fetch_req` after reset SHALL read address 0x0000.

Configuration
REQ-026 Macro `IFU_PREFETCH_EN`, when defined, SHALL add a one-word prefetch buffer with a valid flag.
- After each CAPTURE, the FSM performs one autonomous READ/CAPTURE at the new `pc` into the buffer, with `busy`=1.
- A `fetch_req` with the buffer valid gives `instr` <= buffer, `pc` <= `pc`+1 and `instr_valid` in the cycle after the next edge (1-cycle latency), then starts the next prefetch.
- `pc_load` or `rst` clears the buffer valid flag.
- A `fetch_req` arriving during a prefetch is held and served when the prefetch completes.
REQ-027 Without `IFU_PREFETCH_EN`, the block SHALL behave exactly per REQ-013..REQ-025 and contain no buffer.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset then `fetch_req`, with RAM[0x0000]=0xA5C3 -> `ram_addr`=0x0000 in READ; `instr`=0xA5C3, `instr_valid` pulse 3 cycles after the request; `pc`=0x0001.
- `pc_load`=1 with `pc_load_val`=0x0040 plus `fetch_req` in IDLE, RAM[0x0040]=0x1234 -> READ at 0x0040; `instr`=0x1234; `pc`=0x0041.
- `pc`=0xFFFF, `fetch_req` -> `instr`=RAM[0xFFFF]; `pc`=0x0000.
- `pc_load` with `pc_load_val`=0x0100 during CAPTURE -> no `instr_valid`; `instr` unchanged; `pc`=0x0100; state IDLE.
- `fetch_req` repeated during READ -> exactly one `instr_valid`; `pc` advances by 1 only.
- `rst` asserted during READ -> outputs at reset values without a clock edge; no pulse after release.
- With `IFU_PREFETCH_EN`: second `fetch_req` after the prefetch completes -> `instr_valid` 1 cycle later with RAM[`pc`].

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: control-side request/load, RAM port and
// fetched-instruction outputs, grouped for the instr_fetch_unit.
interface instr_fetch_unit_if;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] ram_rdata;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        busy;

    modport master (
        output fetch_req, pc_load, pc_load_val, ram_rdata,
        input  ram_addr, ram_rd, instr, instr_valid, pc, busy
    );

    modport slave (
        input  fetch_req, pc_load, pc_load_val, ram_rdata,
        output ram_addr, ram_rd, instr, instr_valid, pc, busy
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/READ/CAPTURE FSM over a synchronous RAM.
// Optional macro IFU_PREFETCH_EN adds a one-word prefetch buffer.
module instr_fetch_unit (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] addr_q;
    logic        vld_q, vld_d;
`ifdef IFU_PREFETCH_EN
    logic [15:0] buf_q, buf_d;
    logic        bvld_q, bvld_d;
    logic        pf_q, pf_d;
    logic        pend_q, pend_d;
`endif

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
`ifdef IFU_PREFETCH_EN
            buf_q   <= '0;
            bvld_q  <= 1'b0;
            pf_q    <= 1'b0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            if (state_q == READ) addr_q <= pc_q;
`ifdef IFU_PREFETCH_EN
            buf_q   <= buf_d;
            bvld_q  <= bvld_d;
            pf_q    <= pf_d;
            pend_q  <= pend_d;
`endif
        end
    end

`ifdef IFU_PREFETCH_EN
    // Next state with prefetch: serve from buffer, then refill it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        buf_d   = buf_q;
        bvld_d  = bvld_q;
        pf_d    = pf_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (bus.pc_load) begin
                    pc_d   = bus.pc_load_val;
                    bvld_d = 1'b0;
                    pend_d = 1'b0;
                    if (bus.fetch_req) begin
                        state_d = READ;
                        pf_d    = 1'b0;
                    end
                end else if (bus.fetch_req || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = READ;
                    if (bvld_q) begin
                        instr_d = buf_q;
                        pc_d    = pc_q + 16'd1;
                        vld_d   = 1'b1;
                        bvld_d  = 1'b0;
                        pf_d    = 1'b1;
                    end else begin
                        pf_d    = 1'b0;
                    end
                end
            end
            READ: begin
                if (bus.pc_load) begin
                    pc_d    = bus.pc_load_val;
                    state_d = IDLE;
                    bvld_d  = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = CAPTURE;
                    if (pf_q && bus.fetch_req) pend_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (bus.pc_load) begin
                    pc_d    = bus.pc_load_val;
                    state_d = IDLE;
                    bvld_d  = 1'b0;
                    pend_d  = 1'b0;
                end else if (pf_q) begin
                    buf_d   = bus.ram_rdata;
                    bvld_d  = 1'b1;
                    state_d = IDLE;
                    if (bus.fetch_req) pend_d = 1'b1;
                end else begin
                    instr_d = bus.ram_rdata;
                    pc_d    = pc_q + 16'd1;
                    vld_d   = 1'b1;
                    state_d = READ;
                    pf_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    // Next state: one RAM read per request, pc_load aborts a fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.pc_load)   pc_d    = bus.pc_load_val;
                if (bus.fetch_req) state_d = READ;
            end
            READ: begin
                if (bus.pc_load) begin
                    pc_d    = bus.pc_load_val;
                    state_d = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                if (bus.pc_load) begin
                    pc_d    = bus.pc_load_val;
                end else begin
                    instr_d = bus.ram_rdata;
                    pc_d    = pc_q + 16'd1;
                    vld_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`endif

    // Outputs: RAM strobe/address decoded from state, rest registered.
    always_comb begin
        bus.ram_rd      = (state_q == READ);
        bus.ram_addr    = (state_q == READ) ? pc_q : addr_q;
        bus.busy        = (state_q != IDLE);
        bus.instr       = instr_q;
        bus.instr_valid = vld_q;
        bus.pc          = pc_q;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous RAM model.
// Default build checks the plain FSM; IFU_PREFETCH_EN checks the buffer.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses = 0;

    instr_fetch_unit_if bus_if ();

    instr_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'hA5C3;
            16'h0040: return 16'h1234;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // Synchronous RAM: data appears the cycle after the strobe.
    always @(posedge clk)
        if (bus_if.ram_rd) bus_if.ram_rdata <= mem(bus_if.ram_addr);

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus_if.instr_valid) pulses++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus_if.fetch_req   = 1'b0;
        bus_if.pc_load     = 1'b0;
        bus_if.pc_load_val = '0;
        bus_if.ram_rdata   = '0;
        #2;
        chk("rst_pc", bus_if.pc, 16'h0000);
        chk("rst_instr", bus_if.instr, 16'h0000);
        chk("rst_valid", 16'(bus_if.instr_valid), 16'h0);
        chk("rst_rd", 16'(bus_if.ram_rd), 16'h0);
        chk("rst_addr", bus_if.ram_addr, 16'h0000);
        chk("rst_busy", 16'(bus_if.busy), 16'h0);
        steps(2);
        rst = 1'b0;
        steps(1);

`ifdef IFU_PREFETCH_EN
        bus_if.pc_load = 1'b1;
        bus_if.pc_load_val = 16'h0040;
        bus_if.fetch_req = 1'b1;
        step();
        bus_if.pc_load = 1'b0;
        bus_if.fetch_req = 1'b0;
        chk("pf_addr", bus_if.ram_addr, 16'h0040);
        steps(2);
        chk("pf_v1", 16'(bus_if.instr_valid), 16'h1);
        chk("pf_i1", bus_if.instr, 16'h1234);
        chk("pf_busy", 16'(bus_if.busy), 16'h1);
        chk("pf_paddr", bus_if.ram_addr, 16'h0041);
        steps(2);
        chk("pf_idle", 16'(bus_if.busy), 16'h0);
        bus_if.fetch_req = 1'b1;
        step();
        bus_if.fetch_req = 1'b0;
        chk("pf_v2", 16'(bus_if.instr_valid), 16'h1);
        chk("pf_i2", bus_if.instr, 16'h5A1B);
        chk("pf_pc2", bus_if.pc, 16'h0042);
        steps(3);
`else
        // First fetch after reset reads address 0.
        bus_if.fetch_req = 1'b1;
        step();
        bus_if.fetch_req = 1'b0;
        chk("t1_rd", 16'(bus_if.ram_rd), 16'h1);
        chk("t1_addr", bus_if.ram_addr, 16'h0000);
        chk("t1_busy", 16'(bus_if.busy), 16'h1);
        step();
        chk("t1_nov", 16'(bus_if.instr_valid), 16'h0);
        step();
        chk("t1_v", 16'(bus_if.instr_valid), 16'h1);
        chk("t1_instr", bus_if.instr, 16'hA5C3);
        chk("t1_pc", bus_if.pc, 16'h0001);
        chk("t1_idle", 16'(bus_if.busy), 16'h0);
        step();
        chk("t1_pulse", 16'(bus_if.instr_valid), 16'h0);
        chk("t1_hold", bus_if.ram_addr, 16'h0000);

        // Load plus fetch in IDLE reads the new PC.
        bus_if.pc_load = 1'b1;
        bus_if.pc_load_val = 16'h0040;
        bus_if.fetch_req = 1'b1;
        step();
        bus_if.pc_load = 1'b0;
        bus_if.fetch_req = 1'b0;
        chk("t2_addr", bus_if.ram_addr, 16'h0040);
        steps(2);
        chk("t2_v", 16'(bus_if.instr_valid), 16'h1);
        chk("t2_instr", bus_if.instr, 16'h1234);
        chk("t2_pc", bus_if.pc, 16'h0041);
        step();

        // PC wraps from 0xFFFF to 0.
        bus_if.pc_load = 1'b1;
        bus_if.pc_load_val = 16'hFFFF;
        step();
        bus_if.pc_load = 1'b0;
        chk("t3_ld", bus_if.pc, 16'hFFFF);
        bus_if.fetch_req = 1'b1;
        step();
        bus_if.fetch_req = 1'b0;
        chk("t3_addr", bus_if.ram_addr, 16'hFFFF);
        steps(2);
        chk("t3_instr", bus_if.instr, 16'hA5A5);
        chk("t3_pc", bus_if.pc, 16'h0000);
        step();

        // pc_load during CAPTURE aborts the fetch.
        pulses = 0;
        bus_if.fetch_req = 1'b1;
        step();
        bus_if.fetch_req = 1'b0;
        step();
        bus_if.pc_load = 1'b1;
        bus_if.pc_load_val = 16'h0100;
        step();
        bus_if.pc_load = 1'b0;
        chk("t4_instr", bus_if.instr, 16'hA5A5);
        chk("t4_pc", bus_if.pc, 16'h0100);
        chk("t4_idle", 16'(bus_if.busy), 16'h0);
        steps(3);
        chk("t4_pulses", 16'(pulses), 16'h0);

        // Requests during a fetch are dropped.
        pulses = 0;
        bus_if.fetch_req = 1'b1;
        steps(3);
        bus_if.fetch_req = 1'b0;
        steps(3);
        chk("t5_pulses", 16'(pulses), 16'h1);
        chk("t5_pc", bus_if.pc, 16'h0101);
        chk("t5_instr", bus_if.instr, 16'h5B5A);

        // Asynchronous reset during READ.
        bus_if.fetch_req = 1'b1;
        step();
        bus_if.fetch_req = 1'b0;
        chk("t6_rd", 16'(bus_if.ram_rd), 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rd0", 16'(bus_if.ram_rd), 16'h0);
        chk("t6_busy", 16'(bus_if.busy), 16'h0);
        chk("t6_pc", bus_if.pc, 16'h0000);
        chk("t6_instr", bus_if.instr, 16'h0000);
        chk("t6_addr", bus_if.ram_addr, 16'h0000);
        step();
        rst = 1'b0;
        pulses = 0;
        steps(4);
        chk("t6_pulses", 16'(pulses), 16'h0);
        chk("t6_pc2", bus_if.pc, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
